// File: rtl/fft_stage_ctrl_pkg.sv
// Shared constants, FSM state type and span helper for the 64-point
// radix-2 DIF FFT stage sequencer.
package fft_pkg;

    localparam int LOG2N    = 6;                  // log2 of FFT length
    localparam int N_STAGES = LOG2N;              // one pass per address bit
    localparam int CW       = 6;                  // stage-counter bus width
    localparam int N_BF     = 1 << (LOG2N - 1);   // butterflies per stage

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        FIN
    } fft_ctrl_state_t;

    // Distance between the two wings of a butterfly in the given stage:
    // N/2 in stage 0, halving every stage down to 1 in the last one.
    function automatic logic [LOG2N-1:0] span_of(input logic [CW-1:0] stage);
        logic [LOG2N-1:0] half;
        half = LOG2N'(N_BF);
        return half >> stage;
    endfunction

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Handshake between the stage sequencer (master) and the 64-count stage
// counter (slave): start/stage go out, count/new_stage come back.
interface fft_stage_ctrl_if;
    import fft_pkg::*;

    logic          start;      // one-cycle pulse launching a counter pass
    logic [CW-1:0] stage;      // stage index, stable while a pass runs
    logic [CW-1:0] count;      // 0..63, one step per clock during a pass
    logic          new_stage;  // high in the cycle count == 63

    modport master (
        output start,
        output stage,
        input  count,
        input  new_stage
    );

    modport slave (
        input  start,
        input  stage,
        output count,
        output new_stage
    );

endinterface

// File: rtl/fft_stage_ctrl_bf_addr_gen.sv
// Combinational butterfly address generator: maps (stage, butterfly index)
// to the upper/lower wing addresses and the twiddle ROM index using only
// shifts and masks.
module fft_bf_addr_gen
    import fft_pkg::*;
(
    input  logic [CW-1:0]    stage,
    input  logic [LOG2N-2:0] j,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx
);

    localparam int JW = LOG2N - 1;

    logic [LOG2N-1:0] span;
    logic [JW-1:0]    pos;
    logic [JW-1:0]    grp;

    // j splits into a group number (high bits) and an offset inside the
    // group (low bits); each group occupies 2*span consecutive addresses.
    always_comb begin
        span   = span_of(stage);
        pos    = j & (span[JW-1:0] - JW'(1));
        grp    = j >> (CW'(JW) - stage);
        addr_a = ({1'b0, grp} << (CW'(LOG2N) - stage)) + {1'b0, pos};
        addr_b = addr_a + span;
        tw_idx = pos << stage;
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage sequencer for the 64-point radix-2 DIF FFT. Launches one counter
// pass per stage (0..5), turns each count below 32 into a registered
// butterfly address triple, and pulses done after the last stage.
module fft_stage_ctrl
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic             go,
    output logic             busy,
    output logic             done,
    fft_stage_ctrl_if.master ctr,
    output logic             bf_valid,
    output logic [LOG2N-1:0] bf_addr_a,
    output logic [LOG2N-1:0] bf_addr_b,
    output logic [LOG2N-2:0] tw_idx
);

    fft_ctrl_state_t  state_reg;
    fft_ctrl_state_t  state_next;
    logic [CW-1:0]    stage_reg;
    logic [CW-1:0]    stage_next;

    logic             last_stage;
    logic             in_bf_window;

    logic [LOG2N-1:0] gen_addr_a;
    logic [LOG2N-1:0] gen_addr_b;
    logic [LOG2N-2:0] gen_tw_idx;

    logic             bf_valid_reg;
    logic [LOG2N-1:0] bf_addr_a_reg;
    logic [LOG2N-1:0] bf_addr_b_reg;
    logic [LOG2N-2:0] tw_idx_reg;

    assign last_stage   = (stage_reg == CW'(N_STAGES - 1));
    // Counts 0..31 are butterflies; 32..63 only let the datapath drain.
    assign in_bf_window = (state_reg == RUN) && (ctr.count < CW'(N_BF));

    fft_bf_addr_gen u_addr_gen (
        .stage  (stage_reg),
        .j      (ctr.count[LOG2N-2:0]),
        .addr_a (gen_addr_a),
        .addr_b (gen_addr_b),
        .tw_idx (gen_tw_idx)
    );

    // FSM state and current stage index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            stage_reg <= '0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
        end
    end

    // Next-state logic plus state-decoded handshake outputs
    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        busy       = 1'b0;
        done       = 1'b0;
        ctr.start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (go) begin
                    state_next = LAUNCH;
                    stage_next = '0;
                end
            end
            LAUNCH: begin
                busy       = 1'b1;
                ctr.start  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (ctr.new_stage) begin
                    if (last_stage) begin
                        state_next = FIN;
                    end else begin
                        stage_next = stage_reg + CW'(1);
                        state_next = LAUNCH;
                    end
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ctr.stage = stage_reg;

    // Butterfly outputs, one cycle behind the count; held during the drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bf_valid_reg  <= 1'b0;
            bf_addr_a_reg <= '0;
            bf_addr_b_reg <= '0;
            tw_idx_reg    <= '0;
        end else begin
            bf_valid_reg <= in_bf_window;
            if (in_bf_window) begin
                bf_addr_a_reg <= gen_addr_a;
                bf_addr_b_reg <= gen_addr_b;
                tw_idx_reg    <= gen_tw_idx;
            end
        end
    end

    assign bf_valid  = bf_valid_reg;
    assign bf_addr_a = bf_addr_a_reg;
    assign bf_addr_b = bf_addr_b_reg;
    assign tw_idx    = tw_idx_reg;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl: behavioural stage counter,
// protocol-level expectation model and a butterfly scoreboard built from
// the group/offset definition of a radix-2 DIF stage.
module tb_fft_stage_ctrl;
    import fft_pkg::*;

    logic             clk;
    logic             rst;
    logic             go;
    logic             busy;
    logic             done;
    logic             bf_valid;
    logic [LOG2N-1:0] bf_addr_a;
    logic [LOG2N-1:0] bf_addr_b;
    logic [LOG2N-2:0] tw_idx;

    fft_stage_ctrl_if ctr_if ();

    fft_stage_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .busy      (busy),
        .done      (done),
        .ctr       (ctr_if),
        .bf_valid  (bf_valid),
        .bf_addr_a (bf_addr_a),
        .bf_addr_b (bf_addr_b),
        .tw_idx    (tw_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int a;
        int b;
        int tw;
    } bf_t;

    bf_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // counter model
    int          cnt;
    bit          cnt_run;
    bit          spur_ns;

    // protocol model
    bit          m_active;
    bit          m_done_now;
    int          m_pass;
    int          m_ffts;
    int          dut_dones;
    int          pass_pulses;
    logic [63:0] cov;

    int          obs_a  [N_STAGES][32];
    int          obs_b  [N_STAGES][32];
    int          obs_tw [N_STAGES][32];

    task automatic check_eq(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Expected butterflies of a whole FFT, in issue order: stage s has
    // 2**s groups of span = 32/2**s butterflies, twiddle step 2**s.
    task automatic load_expected();
        exp_q.delete();
        for (int s = 0; s < N_STAGES; s++) begin
            int groups;
            int span;
            groups = 2 ** s;
            span   = 32 / groups;
            for (int g = 0; g < groups; g++) begin
                for (int k = 0; k < span; k++) begin
                    bf_t e;
                    e.a  = g * 2 * span + k;
                    e.b  = e.a + span;
                    e.tw = (k * groups) % 32;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // One clock: advance counter model, then check every DUT output.
    task automatic cycle();
        bit  go_pre, ns_pre, start_pre, run_pre;
        bit  exp_start, exp_done, exp_valid;
        int  cnt_pre, s_pre;
        bf_t e;
        go_pre    = go;
        ns_pre    = ctr_if.new_stage;
        start_pre = ctr_if.start;
        run_pre   = cnt_run;
        cnt_pre   = cnt;
        s_pre     = m_pass - 1;

        @(posedge clk);
        #1;

        if (start_pre) begin
            cnt     = 0;
            cnt_run = 1'b1;
        end else if (cnt_run) begin
            if (cnt == 63) cnt_run = 1'b0;
            else           cnt++;
        end
        ctr_if.count     = 6'(cnt);
        ctr_if.new_stage = (cnt_run && cnt == 63) || spur_ns;
        spur_ns          = 1'b0;

        if (done) dut_dones++;

        exp_valid = run_pre && (cnt_pre < 32);
        check_eq("bf_valid", bf_valid, exp_valid);
        if (exp_valid && bf_valid) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("bf_addr_a", bf_addr_a, e.a);
                check_eq("bf_addr_b", bf_addr_b, e.b);
                check_eq("tw_idx", tw_idx, e.tw);
                cov[bf_addr_a] = 1'b1;
                cov[bf_addr_b] = 1'b1;
                pass_pulses++;
                if (s_pre >= 0 && s_pre < N_STAGES) begin
                    obs_a[s_pre][cnt_pre]  = bf_addr_a;
                    obs_b[s_pre][cnt_pre]  = bf_addr_b;
                    obs_tw[s_pre][cnt_pre] = tw_idx;
                end
            end else begin
                check_eq("bf_queue_len", exp_q.size(), 1);
            end
        end

        exp_start = 1'b0;
        exp_done  = 1'b0;
        if (!m_active && !m_done_now && go_pre) begin
            m_active    = 1'b1;
            m_pass      = 1;
            exp_start   = 1'b1;
            pass_pulses = 0;
            cov         = '0;
            load_expected();
        end else if (m_active && ns_pre) begin
            check_eq("bf_per_stage", pass_pulses, 32);
            check_eq("stage_cover", int'(cov == {64{1'b1}}), 1);
            pass_pulses = 0;
            cov         = '0;
            if (m_pass == N_STAGES) begin
                m_active = 1'b0;
                exp_done = 1'b1;
                m_ffts++;
                check_eq("bf_left", exp_q.size(), 0);
            end else begin
                m_pass++;
                exp_start = 1'b1;
            end
        end
        m_done_now = exp_done;

        check_eq("ctr_start", ctr_if.start, exp_start);
        check_eq("done", done, exp_done);
        check_eq("busy", busy, m_active);
        if (m_active) check_eq("ctr_stage", ctr_if.stage, m_pass - 1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!m_done_now && k < budget) begin
            cycle();
            k++;
        end
        check_eq("done_in_time", int'(m_done_now), 1);
    endtask

    task automatic start_fft(input int gap, input int hold);
        repeat (gap) cycle();
        go = 1'b1;
        repeat (hold) cycle();
        go = 1'b0;
    endtask

    initial begin
        int target;
        int k;

        rst              = 1'b0;
        go               = 1'b0;
        ctr_if.count     = '0;
        ctr_if.new_stage = 1'b0;
        cnt              = 0;
        cnt_run          = 1'b0;
        spur_ns          = 1'b0;
        m_active         = 1'b0;
        m_done_now       = 1'b0;
        m_pass           = 0;
        m_ffts           = 0;
        dut_dones        = 0;
        pass_pulses      = 0;
        cov              = '0;
        for (int s = 0; s < N_STAGES; s++) begin
            for (int j = 0; j < 32; j++) begin
                obs_a[s][j]  = -1;
                obs_b[s][j]  = -1;
                obs_tw[s][j] = -1;
            end
        end

        // reset state
        repeat (3) cycle();
        check_eq("rst_stage", ctr_if.stage, 0);
        check_eq("rst_addr_a", bf_addr_a, 0);
        check_eq("rst_addr_b", bf_addr_b, 0);
        check_eq("rst_tw", tw_idx, 0);
        rst = 1'b1;

        // single FFT plus address spot checks
        start_fft($urandom_range(1, 5), 1);
        wait_done(600);
        check_eq("spot0_a", obs_a[0][5], 5);
        check_eq("spot0_b", obs_b[0][5], 37);
        check_eq("spot0_tw", obs_tw[0][5], 5);
        check_eq("spot1_a", obs_a[1][20], 36);
        check_eq("spot1_b", obs_b[1][20], 52);
        check_eq("spot1_tw", obs_tw[1][20], 8);
        check_eq("spot5_a", obs_a[5][3], 6);
        check_eq("spot5_b", obs_b[5][3], 7);
        check_eq("spot5_tw", obs_tw[5][3], 0);
        check_eq("spot2_a", obs_a[2][31], 55);
        check_eq("spot2_b", obs_b[2][31], 63);
        check_eq("spot2_tw", obs_tw[2][31], 28);

        // spurious new_stage while idle must not start anything
        repeat (2) cycle();
        spur_ns = 1'b1;
        repeat (4) cycle();
        start_fft($urandom_range(1, 4), 1);
        wait_done(600);

        // go held high across a run: one FFT, then a fresh one from idle
        go = 1'b1;
        cycle();
        wait_done(600);
        cycle();
        cycle();
        go = 1'b0;
        wait_done(600);

        // asynchronous reset in the middle of stage 3
        start_fft($urandom_range(1, 4), 1);
        target = $urandom_range(0, 63);
        k = 0;
        while (!(m_pass == 4 && cnt_run && cnt >= target) && k < 1000) begin
            cycle();
            k++;
        end
        check_eq("reached_stage3", m_pass, 4);
        rst = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_valid", bf_valid, 0);
        check_eq("arst_stage", ctr_if.stage, 0);
        check_eq("arst_done", done, 0);
        m_active    = 1'b0;
        m_done_now  = 1'b0;
        cnt_run     = 1'b0;
        pass_pulses = 0;
        cov         = '0;
        exp_q.delete();
        repeat (2) cycle();
        rst = 1'b1;
        repeat (5) cycle();
        start_fft($urandom_range(1, 4), 1);
        wait_done(600);

        // random gaps and go lengths
        for (int r = 0; r < 2; r++) begin
            start_fft($urandom_range(1, 8), $urandom_range(1, 3));
            wait_done(600);
        end
        repeat (3) cycle();

        check_eq("fft_count", dut_dones, m_ffts);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
